// File: rtl/mem_bus_arbiter_if.sv
// Pipeline-side and memory-bus-side signal bundle for mem_bus_arbiter.
// master: arbiter view; slave: pipeline/memory environment view.
interface mem_bus_arbiter_if;
    logic [5:0]  stall_i;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        stallreq_if_o;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        stallreq_mem_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        bus_err_o;

    modport master (
        input  stall_i, if_ce_i, if_addr_i, mem_ce_i, mem_we_i, mem_sel_i,
               mem_addr_i, mem_wdata_i, bus_ack_i, bus_rdata_i,
        output if_data_o, stallreq_if_o, mem_rdata_o, stallreq_mem_o,
               bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, bus_err_o
    );

    modport slave (
        output stall_i, if_ce_i, if_addr_i, mem_ce_i, mem_we_i, mem_sel_i,
               mem_addr_i, mem_wdata_i, bus_ack_i, bus_rdata_i,
        input  if_data_o, stallreq_if_o, mem_rdata_o, stallreq_mem_o,
               bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, bus_err_o
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates instruction fetch and MEM-stage accesses onto one memory bus; MEM wins.
// Define ARB_TIMEOUT_EN to add a 255-cycle bus watchdog driving bus_err_o.
//
// state   | meaning
// IDLE    | no access on the bus; pick MEM first, then IF
// IF_ACC  | instruction read in flight, waiting for bus_ack_i
// MEM_ACC | load/store in flight, waiting for bus_ack_i
module mem_bus_arbiter (
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_ACC  = 2'd1,
        MEM_ACC = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        if_done, mem_done;
    logic        req_q, we_q;
    logic [3:0]  sel_q;
    logic [31:0] addr_q, wdata_q, if_data_q, mem_rdata_q;
    logic        start_if, start_mem, fin_if, fin_mem;
    logic        timeout;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            tmo_cnt <= 8'd0;
        else if (state == IDLE || fin_if || fin_mem)
            tmo_cnt <= 8'd0;
        else
            tmo_cnt <= tmo_cnt + 8'd1;
    end

    // Count reaches 255 at the end of the 255th access cycle; an ack that cycle wins.
    assign timeout = (state != IDLE) && (tmo_cnt == 8'd254) && !bus.bus_ack_i;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_if  = 1'b0;
        start_mem = 1'b0;
        fin_if    = 1'b0;
        fin_mem   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mem_ce_i && !mem_done) begin
                    state_nxt = MEM_ACC;
                    start_mem = 1'b1;
                end else if (bus.if_ce_i && !if_done) begin
                    state_nxt = IF_ACC;
                    start_if  = 1'b1;
                end
            end
            IF_ACC: begin
                if (bus.bus_ack_i || timeout) begin
                    state_nxt = IDLE;
                    fin_if    = 1'b1;
                end
            end
            MEM_ACC: begin
                if (bus.bus_ack_i || timeout) begin
                    state_nxt = IDLE;
                    fin_mem   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'h0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            if_data_q   <= 32'h0;
            mem_rdata_q <= 32'h0;
            if_done     <= 1'b0;
            mem_done    <= 1'b0;
        end else begin
            if (start_mem) begin
                req_q   <= 1'b1;
                we_q    <= bus.mem_we_i;
                sel_q   <= bus.mem_sel_i;
                addr_q  <= bus.mem_addr_i;
                wdata_q <= bus.mem_wdata_i;
            end else if (start_if) begin
                req_q   <= 1'b1;
                we_q    <= 1'b0;
                sel_q   <= 4'hF;
                addr_q  <= bus.if_addr_i;
                wdata_q <= 32'h0;
            end else if (fin_if || fin_mem) begin
                req_q <= 1'b0;
            end

            if (fin_if)
                if_data_q <= bus.bus_ack_i ? bus.bus_rdata_i : 32'h0;

            // A completed store keeps the last load data; a timed-out access zeroes it.
            if (fin_mem && !(bus.bus_ack_i && we_q))
                mem_rdata_q <= bus.bus_ack_i ? bus.bus_rdata_i : 32'h0;

            if (fin_if)
                if_done <= 1'b1;
            else if (!bus.stall_i[1])
                if_done <= 1'b0;

            if (fin_mem)
                mem_done <= 1'b1;
            else if (!bus.stall_i[4])
                mem_done <= 1'b0;
        end
    end

    assign bus.bus_req_o      = req_q;
    assign bus.bus_we_o       = we_q;
    assign bus.bus_sel_o      = sel_q;
    assign bus.bus_addr_o     = addr_q;
    assign bus.bus_wdata_o    = wdata_q;
    assign bus.if_data_o      = if_data_q;
    assign bus.mem_rdata_o    = mem_rdata_q;
    assign bus.stallreq_if_o  = bus.if_ce_i && !if_done;
    assign bus.stallreq_mem_o = bus.mem_ce_i && !mem_done;
    assign bus.bus_err_o      = timeout;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch, store/fetch contention, no-preempt,
// stall hold, reset mid-access and (with ARB_TIMEOUT_EN) the watchdog.
module tb_mem_bus_arbiter;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst                = 1'b1;
        bus.stall_i        = 6'd0;
        bus.if_ce_i        = 1'b0;
        bus.if_addr_i      = 32'h0;
        bus.mem_ce_i       = 1'b0;
        bus.mem_we_i       = 1'b0;
        bus.mem_sel_i      = 4'h0;
        bus.mem_addr_i     = 32'h0;
        bus.mem_wdata_i    = 32'h0;
        bus.bus_ack_i      = 1'b0;
        bus.bus_rdata_i    = 32'h0;

        // reset values
        cyc();
        cyc();
        chk("rst_req", bus.bus_req_o, 1'b0);
        chk("rst_sel", bus.bus_sel_o, 4'h0);
        chk("rst_addr", bus.bus_addr_o, 32'h0);
        chk("rst_if_data", bus.if_data_o, 32'h0);
        chk("rst_mem_rdata", bus.mem_rdata_o, 32'h0);
        chk("rst_err", bus.bus_err_o, 1'b0);
        rst = 1'b0;

        // zero-wait fetch
        cyc();
        bus.if_ce_i   = 1'b1;
        bus.if_addr_i = 32'h100;
        #1;
        chk("a_stallreq_if_c0", bus.stallreq_if_o, 1'b1);
        chk("a_req_c0", bus.bus_req_o, 1'b0);
        cyc();
        chk("a_req_c1", bus.bus_req_o, 1'b1);
        chk("a_addr_c1", bus.bus_addr_o, 32'h100);
        chk("a_sel_c1", bus.bus_sel_o, 4'hF);
        chk("a_we_c1", bus.bus_we_o, 1'b0);
        chk("a_stallreq_if_c1", bus.stallreq_if_o, 1'b1);
        bus.bus_ack_i   = 1'b1;
        bus.bus_rdata_i = 32'hDEADBEEF;
        cyc();
        bus.bus_ack_i   = 1'b0;
        bus.bus_rdata_i = 32'h0;
        #1;
        chk("a_req_c2", bus.bus_req_o, 1'b0);
        chk("a_if_data", bus.if_data_o, 32'hDEADBEEF);
        chk("a_stallreq_if_c2", bus.stallreq_if_o, 1'b0);
        cyc();
        bus.if_ce_i = 1'b0;
        chk("a_no_refetch", bus.bus_req_o, 1'b0);
        chk("a_if_data_hold", bus.if_data_o, 32'hDEADBEEF);

        // simultaneous store and fetch: store first
        cyc();
        bus.if_ce_i     = 1'b1;
        bus.if_addr_i   = 32'h104;
        bus.mem_ce_i    = 1'b1;
        bus.mem_we_i    = 1'b1;
        bus.mem_sel_i   = 4'b0011;
        bus.mem_addr_i  = 32'h200;
        bus.mem_wdata_i = 32'h12345678;
        #1;
        chk("b_stallreq_mem", bus.stallreq_mem_o, 1'b1);
        chk("b_stallreq_if", bus.stallreq_if_o, 1'b1);
        cyc();
        chk("b_req_mem", bus.bus_req_o, 1'b1);
        chk("b_we_mem", bus.bus_we_o, 1'b1);
        chk("b_sel_mem", bus.bus_sel_o, 4'b0011);
        chk("b_addr_mem", bus.bus_addr_o, 32'h200);
        chk("b_wdata_mem", bus.bus_wdata_o, 32'h12345678);
        bus.bus_ack_i   = 1'b1;
        bus.bus_rdata_i = 32'hBAD0BAD0;
        cyc();
        bus.bus_ack_i   = 1'b0;
        bus.bus_rdata_i = 32'h0;
        #1;
        chk("b_req_gap", bus.bus_req_o, 1'b0);
        chk("b_stallreq_mem_done", bus.stallreq_mem_o, 1'b0);
        chk("b_store_keeps_rdata", bus.mem_rdata_o, 32'h0);
        chk("b_stallreq_if_wait", bus.stallreq_if_o, 1'b1);
        cyc();
        bus.mem_ce_i = 1'b0;
        bus.mem_we_i = 1'b0;
        chk("b_req_if", bus.bus_req_o, 1'b1);
        chk("b_addr_if", bus.bus_addr_o, 32'h104);
        chk("b_we_if", bus.bus_we_o, 1'b0);
        chk("b_sel_if", bus.bus_sel_o, 4'hF);
        bus.bus_ack_i   = 1'b1;
        bus.bus_rdata_i = 32'hCAFEF00D;
        cyc();
        bus.bus_ack_i   = 1'b0;
        bus.bus_rdata_i = 32'h0;
        #1;
        chk("b_if_data", bus.if_data_o, 32'hCAFEF00D);
        chk("b_req_end", bus.bus_req_o, 1'b0);
        chk("b_mem_rdata_end", bus.mem_rdata_o, 32'h0);
        bus.if_ce_i = 1'b0;

        // slow fetch, MEM arrives mid-fetch and must wait
        cyc();
        bus.if_ce_i   = 1'b1;
        bus.if_addr_i = 32'h108;
        cyc();
        chk("c_req_if1", bus.bus_req_o, 1'b1);
        cyc();
        bus.mem_ce_i   = 1'b1;
        bus.mem_we_i   = 1'b0;
        bus.mem_sel_i  = 4'hF;
        bus.mem_addr_i = 32'h300;
        #1;
        chk("c_stallreq_mem_wait", bus.stallreq_mem_o, 1'b1);
        chk("c_addr_if2", bus.bus_addr_o, 32'h108);
        cyc();
        chk("c_req_if3", bus.bus_req_o, 1'b1);
        chk("c_addr_if3", bus.bus_addr_o, 32'h108);
        bus.bus_ack_i   = 1'b1;
        bus.bus_rdata_i = 32'h11112222;
        cyc();
        bus.bus_ack_i   = 1'b0;
        bus.bus_rdata_i = 32'h0;
        #1;
        chk("c_if_data", bus.if_data_o, 32'h11112222);
        chk("c_req_gap", bus.bus_req_o, 1'b0);
        chk("c_stallreq_mem_gap", bus.stallreq_mem_o, 1'b1);
        bus.if_ce_i = 1'b0;
        cyc();
        chk("c_req_mem", bus.bus_req_o, 1'b1);
        chk("c_addr_mem", bus.bus_addr_o, 32'h300);
        chk("c_we_mem", bus.bus_we_o, 1'b0);
        chk("c_stallreq_mem_acc", bus.stallreq_mem_o, 1'b1);
        bus.stall_i[4]  = 1'b1;
        bus.bus_ack_i   = 1'b1;
        bus.bus_rdata_i = 32'h33334444;
        cyc();
        bus.bus_ack_i   = 1'b0;
        bus.bus_rdata_i = 32'h0;
        #1;
        chk("c_mem_rdata", bus.mem_rdata_o, 32'h33334444);
        chk("c_stallreq_mem_done", bus.stallreq_mem_o, 1'b0);
        chk("c_req_done", bus.bus_req_o, 1'b0);

        // MEM/WB held for 4 cycles: no repeat access
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("d_hold_req", bus.bus_req_o, 1'b0);
            chk("d_hold_rdata", bus.mem_rdata_o, 32'h33334444);
            chk("d_hold_stallreq", bus.stallreq_mem_o, 1'b0);
        end
        bus.stall_i[4] = 1'b0;
        cyc();
        chk("d_done_cleared", bus.stallreq_mem_o, 1'b1);
        chk("d_no_access", bus.bus_req_o, 1'b0);
        bus.mem_ce_i = 1'b0;

        // reset in the second MEM_ACC cycle, late ack ignored
        cyc();
        bus.mem_ce_i   = 1'b1;
        bus.mem_sel_i  = 4'hF;
        bus.mem_addr_i = 32'h400;
        cyc();
        chk("e_req1", bus.bus_req_o, 1'b1);
        cyc();
        chk("e_req2", bus.bus_req_o, 1'b1);
        rst = 1'b1;
        cyc();
        rst             = 1'b0;
        bus.mem_ce_i    = 1'b0;
        bus.bus_ack_i   = 1'b1;
        bus.bus_rdata_i = 32'h55556666;
        chk("e_rst_req", bus.bus_req_o, 1'b0);
        chk("e_rst_addr", bus.bus_addr_o, 32'h0);
        chk("e_rst_sel", bus.bus_sel_o, 4'h0);
        chk("e_rst_mem_rdata", bus.mem_rdata_o, 32'h0);
        chk("e_rst_if_data", bus.if_data_o, 32'h0);
        cyc();
        bus.bus_ack_i   = 1'b0;
        bus.bus_rdata_i = 32'h0;
        chk("e_late_ack_rdata", bus.mem_rdata_o, 32'h0);
        chk("e_late_ack_req", bus.bus_req_o, 1'b0);

`ifdef ARB_TIMEOUT_EN
        // watchdog: load with no ack
        cyc();
        bus.mem_ce_i   = 1'b1;
        bus.mem_we_i   = 1'b0;
        bus.mem_addr_i = 32'h500;
        cyc();
        chk("f_req1", bus.bus_req_o, 1'b1);
        repeat (253) cyc();
        #1;
        chk("f_err_254", bus.bus_err_o, 1'b0);
        cyc();
        #1;
        chk("f_err_255", bus.bus_err_o, 1'b1);
        chk("f_stallreq_255", bus.stallreq_mem_o, 1'b1);
        cyc();
        #1;
        chk("f_err_after", bus.bus_err_o, 1'b0);
        chk("f_stallreq_after", bus.stallreq_mem_o, 1'b0);
        chk("f_mem_rdata", bus.mem_rdata_o, 32'h0);
        chk("f_req_after", bus.bus_req_o, 1'b0);
        bus.mem_ce_i = 1'b0;
        cyc();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Clock and reset: one clock; reset is synchronous and active-high. Ports are named clk and rst.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 rst  in  1  synchronous reset, active-high.
REQ-004 stall_i  in  6  pipeline stall vector from the control unit; bit 1 is IF/ID, bit 4 is MEM/WB; 1 means stop.
REQ-005 if_ce_i  in  1  the fetch stage requests an instruction read.
REQ-006 if_addr_i  in  32  fetch address.
REQ-007 if_data_o  out  32  fetched word, held stable until if_done clears.
REQ-008 stallreq_if_o  out  1  fetch stall request to the control unit.
REQ-009 mem_ce_i  in  1  the MEM stage requests a load or store.
REQ-010 mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i  in  1/4/32/32  write enable, byte lanes, address and store data.
REQ-011 mem_rdata_o  out  32  load data, held stable until mem_done clears.
REQ-012 stallreq_mem_o  out  1  MEM stall request to the control unit.
REQ-013 bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o  out  1/1/4/32/32  shared single-port memory bus.
REQ-014 bus_ack_i, bus_rdata_i  in  1/32  bus completion strobe and read data; rdata is valid in the ack cycle.
REQ-015 bus_err_o  out  1  one-cycle timeout error pulse; present only under REQ-031.

Function
REQ-016 States: IDLE, IF_ACC, MEM_ACC; encoding is 2 bits.
REQ-017 IDLE: when mem_ce_i & ~mem_done, go to MEM_ACC; otherwise when if_ce_i & ~if_done, go to IF_ACC; otherwise stay in IDLE. MEM has priority in every cycle, including when both requesters ask at once.
REQ-018 The bus fields are registered on IDLE exit and held constant until ack; bus_req_o is 1 throughout IF_ACC and MEM_ACC, and 0 in IDLE.
REQ-019 IF_ACC: in the if_ack cycle, capture bus_rdata_i into if_data_o, set if_done, drop bus_req_o and return to IDLE; bus_we_o=0 and bus_sel_o=4'b1111 throughout.
REQ-020 MEM_ACC: in the ack cycle, capture bus_rdata_i into mem_rdata_o only for reads (a store leaves mem_rdata_o unchanged), set mem_done and return to IDLE.
REQ-021 stallreq_if_o = if_ce_i & ~if_done; stallreq_mem_o = mem_ce_i & ~mem_done. Both are combinational.
REQ-022 if_done clears on any cycle with stall_i[1]=0; mem_done clears on any cycle with stall_i[4]=0. A clear has priority over a same-cycle set only when the ack belongs to the other requester.
REQ-023 Minimum latency: request seen in IDLE -> bus_req_o the next cycle -> ack at the earliest in that same cycle -> stallreq falls the cycle after ack. A zero-wait access therefore stalls for 2 cycles.
REQ-024 An in-flight IF_ACC is never preempted. A MEM request arriving during IF_ACC waits for the return to IDLE, then wins.
REQ-025 bus_ack_i in IDLE is ignored.
REQ-026 if_ce_i falling during IF_ACC still completes the access; the result is discarded by clearing if_done when stall_i[1]=0.

Reset
REQ-027 When rst=1 at a clock edge: state=IDLE, if_done=mem_done=0, bus_req_o=0, bus_we_o=0, bus_sel_o=0, bus_addr_o=0, bus_wdata_o=0, if_data_o=0, mem_rdata_o=0, bus_err_o=0, timeout counter=0.
REQ-028 A reset during IF_ACC or MEM_ACC abandons the access; an ack in the following cycle is ignored per REQ-025.

Configuration
REQ-029 Macro ARB_TIMEOUT_EN selects the bus watchdog.
REQ-030 With ARB_TIMEOUT_EN undefined: no counter; an access waits for ack indefinitely; bus_err_o is tied to 0.
REQ-031 With ARB_TIMEOUT_EN defined: an 8-bit counter increments each cycle in IF_ACC or MEM_ACC. When it reaches 255 without ack:
- pulse bus_err_o for 1 cycle;
- load 32'h0 into the active requester's data register;
- set its done flag;
- go to IDLE;
- clear the counter.
An ack in that same cycle takes precedence and no error is raised.

Verification
REQ-032 if_ce_i=1, addr 0x100, ack in the first bus cycle with rdata 0xDEADBEEF -> bus_req_o high for 1 cycle, if_data_o=0xDEADBEEF, stallreq_if_o high for exactly 2 cycles.
REQ-033 if_ce_i and mem_ce_i rise together, mem_we_i=1, sel 4'b0011, addr 0x200 -> the MEM store is issued first with bus_sel_o=0011; IF is issued immediately after the MEM ack; mem_rdata_o is unchanged.
REQ-034 IF_ACC in progress with a 3-cycle ack delay, mem_ce_i rises in its second cycle -> IF completes, then MEM_ACC starts the next cycle; stallreq_mem_o stays high until the cycle after the MEM ack.
REQ-035 After a load completes, hold stall_i[4]=1 for 4 cycles -> no second bus access, mem_rdata_o stable. Then stall_i[4]=0 -> mem_done clears.
REQ-036 rst asserted in the 2nd cycle of MEM_ACC -> all outputs at their reset values next cycle; a late ack is ignored.
REQ-037 ARB_TIMEOUT_EN defined, ack never given -> bus_err_o pulses on the 255th access cycle, mem_rdata_o=0, stallreq_mem_o drops on the following cycle.
